// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single memory port between the CPU control unit and the DMA/debug
// loader. A registered FSM (IDLE -> ADDR -> WAIT -> RESP) picks a winner in
// IDLE, presents the command for one ADDR cycle, waits for mem_data_ready (or
// gives up after TIMEOUT cycles), and returns a one-cycle done pulse with read
// data and error status to the port that owned the transaction.
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   cpu_req/write/addr/wdata/size   CPU request and payload, held until cpu_done
//   cpu_done/err/rdata              CPU completion pulse, timeout flag, read data
//   dma_*                           same set for the DMA/debug loader port
//   mem_read/write/addr/wdata/size  memory command, driven from the latched payload
//   mem_addr_ready                  one-cycle command valid (ADDR state)
//   mem_data_ready, mem_rdata       memory completion and read data
//   owner                           0 = CPU, 1 = DMA (current or last grantee)
//   busy                            FSM is not in IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [3:0]        cpu_size,
   output logic              cpu_done,
   output logic              cpu_err,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_write,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic [3:0]        dma_size,
   output logic              dma_done,
   output logic              dma_err,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_size,
   output logic              mem_addr_ready,
   input  logic              mem_data_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner,
   output logic              busy
);

   // Timeout counter only needs to reach TIMEOUT-1: the transition out of WAIT
   // happens on the cycle the counter shows that value.
   localparam int                TMO_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [3:0]        STARVE_MAX = 4'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

   state_t             state, next_state;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [3:0]         starve_cnt;
   logic               lat_write;

   logic               any_req, grant_dma, timeout_hit, finish;
   logic               owner_d, write_d, strobe_on;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_d, resp_rdata;
   logic [3:0]         mem_size_d;

   assign any_req     = cpu_req | dma_req;
   // CPU has fixed priority unless the DMA port has been passed over MAX_WAIT times.
   assign grant_dma   = dma_req & (~cpu_req | (starve_cnt >= STARVE_MAX));
   assign timeout_hit = (tmo_cnt == TMO_LAST);

   // Next-state logic
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      next_state = state;
      unique case (state)
         IDLE:    if (any_req) next_state = ADDR;
         ADDR:    next_state = WAIT;
         WAIT:    if (mem_data_ready || timeout_hit) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output logic: computes the value each output register takes at the next edge.
   always_comb begin
      owner_d     = owner;
      write_d     = lat_write;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_size_d  = mem_size;
      if (state == IDLE && any_req) begin
         owner_d     = grant_dma;
         write_d     = grant_dma ? dma_write : cpu_write;
         mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
         mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
         mem_size_d  = grant_dma ? dma_size  : cpu_size;
      end
      strobe_on  = (next_state == ADDR) || (next_state == WAIT);
      finish     = (state == WAIT) && (next_state == RESP);
      // A completion that coincides with the timeout counts as a success.
      resp_rdata = mem_data_ready ? mem_rdata : '0;
   end

   // State, counters and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         starve_cnt     <= '0;
         lat_write      <= 1'b0;
         owner          <= 1'b0;
         busy           <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_addr_ready <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         mem_size       <= '0;
         cpu_done       <= 1'b0;
         cpu_err        <= 1'b0;
         cpu_rdata      <= '0;
         dma_done       <= 1'b0;
         dma_err        <= 1'b0;
         dma_rdata      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state          <= next_state;
         lat_write      <= write_d;
         owner          <= owner_d;
         busy           <= (next_state != IDLE);
         mem_read       <= strobe_on & ~write_d;
         mem_write      <= strobe_on & write_d;
         mem_addr_ready <= (next_state == ADDR);
         mem_addr       <= mem_addr_d;
         mem_wdata      <= mem_wdata_d;
         mem_size       <= mem_size_d;

         if (state == WAIT && next_state == WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
         else                                      tmo_cnt <= '0;

         // One update per arbitration decision; saturates at 15.
         if (state == IDLE) begin
            if (!dma_req || grant_dma)    starve_cnt <= '0;
            else if (starve_cnt != 4'hF)  starve_cnt <= starve_cnt + 4'd1;
         end

         cpu_done <= finish & ~owner;
         dma_done <= finish & owner;
         // rdata/err hold until the next completion for the same port.
         if (finish && !owner) begin
            cpu_rdata <= resp_rdata;
            cpu_err   <= ~mem_data_ready;
         end
         if (finish && owner) begin
            dma_rdata <= resp_rdata;
            dma_err   <= ~mem_data_ready;
         end
      end
   end

endmodule
